// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter.
// State encodings and default timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DEF_STALL_CYCLES = 8;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first valid bit at or above ptr,
// wrapping around, returned one-hot and as an index.
module rr_select #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  valid,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   pos;
    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            j = pos[IW-1:0];
            if (!any && valid[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers,
// with optional per-requester burst lock capped at MAX_BURST bytes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_lock,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_data_send,
    output logic                 o_tx_valid,
    input  logic                 i_ready_tx,
    output logic [2:0]           o_grant_id,
    output logic                 o_busy,
    output logic                 o_stall
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);

    arb_state_t state, state_d;

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      rr_idx;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] rr_oh;
    logic [NUM_REQ-1:0] win_oh;
    logic [BW-1:0]      burst_cnt;
    logic [BW-1:0]      burst_next;
    logic [SW-1:0]      stall_cnt;
    logic [7:0]         win_data;
    logic               win_lock;
    logic               lock_held;
    logic               lock_win;
    logic               owner_valid;
    logic               rr_any;
    logic               grant;
    logic               stall_fire;

    rr_select #(
        .N(NUM_REQ)
    ) u_rr (
        .ptr  (rr_ptr),
        .valid(i_req_valid),
        .gnt  (rr_oh),
        .idx  (rr_idx),
        .any  (rr_any)
    );

    // A held lock only counts while its owner still presents a byte.
    assign owner_valid = i_req_valid[owner_q];
    assign lock_win    = lock_held & owner_valid;

    always_comb begin
        win_oh  = rr_oh;
        win_idx = rr_idx;
        if (lock_win) begin
            win_oh          = '0;
            win_oh[owner_q] = 1'b1;
            win_idx         = owner_q;
        end
    end

    always_comb begin
        win_data = '0;
        win_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_data = i_req_data[8*i +: 8];
                win_lock = i_req_lock[i];
            end
        end
    end

    assign grant       = i_rst_n && (state == ST_IDLE) && i_ready_tx && rr_any;
    assign o_req_ready = grant ? win_oh : '0;
    assign burst_next  = lock_win ? burst_cnt + 1'b1 : BW'(1);

    assign o_tx_valid = (state == ST_ISSUE);
    assign o_busy     = (state != ST_IDLE);
    assign o_grant_id = 3'(owner_q);

    always_comb begin
        state_d    = state;
        stall_fire = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!i_ready_tx) begin
                    state_d = ST_WAIT_DONE;
                end else if (stall_cnt == SW'(STALL_CYCLES - 1)) begin
                    stall_fire = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_ready_tx) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            owner_q     <= '0;
            burst_cnt   <= '0;
            lock_held   <= 1'b0;
            stall_cnt   <= '0;
            o_data_send <= '0;
            o_stall     <= 1'b0;
        end else begin
            state   <= state_d;
            o_stall <= stall_fire;
            if (grant) begin
                o_data_send <= win_data;
                owner_q     <= win_idx;
                rr_ptr      <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                burst_cnt   <= burst_next;
                lock_held   <= win_lock && (burst_next < BW'(MAX_BURST));
            end else if (stall_fire || (state == ST_IDLE && !owner_valid)) begin
                lock_held <= 1'b0;
            end
            // Stall timer restarts on every issued byte.
            if (state == ST_ISSUE) begin
                stall_cnt <= '0;
            end else if (state == ST_WAIT_BUSY) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int MAXB  = 3;
    localparam int STALL = 8;
    localparam int FRAME = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   r_valid = '0;
    logic [N-1:0]   r_lock = '0;
    logic [8*N-1:0] r_data = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     data_send;
    logic           tx_valid;
    logic           ready_tx;
    logic [2:0]     grant_id;
    logic           busy;
    logic           stall;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .MAX_BURST   (MAXB),
        .STALL_CYCLES(STALL)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(r_valid),
        .i_req_data (r_data),
        .i_req_lock (r_lock),
        .o_req_ready(req_ready),
        .o_data_send(data_send),
        .o_tx_valid (tx_valid),
        .i_ready_tx (ready_tx),
        .o_grant_id (grant_id),
        .o_busy     (busy),
        .o_stall    (stall)
    );

    always #5 clk = ~clk;

    // Stand-in transmitter: busy for FRAME cycles after each pulse.
    int         ucnt = 0;
    bit         stall_mode = 1'b0;
    logic [7:0] tx_log[$];

    assign ready_tx = stall_mode || (ucnt == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt <= 0;
        end else if (tx_valid) begin
            if (!stall_mode) ucnt <= FRAME;
            tx_log.push_back(data_send);
        end else if (ucnt > 0) begin
            ucnt <= ucnt - 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-requester pending bytes: {lock, data}
    logic [8:0] rq[N][$];
    bit         rand_en = 1'b0;

    int         m_ptr, m_owner, m_burst, m_cur;
    bit         m_lock, m_txv_due, m_stall_due;
    logic [7:0] m_data;
    logic [7:0] exp_log[$];
    int         cyc = 0;
    int         t_issue = 0;
    int         stall_dist = -1;

    task automatic model_reset();
        m_ptr       = 0;
        m_owner     = 0;
        m_burst     = 0;
        m_cur       = 0;
        m_lock      = 1'b0;
        m_txv_due   = 1'b0;
        m_stall_due = 1'b0;
        m_data      = 8'h00;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic tick();
        logic [N-1:0] exp_rdy;
        int w;
        @(negedge clk);
        cyc++;
        check("busy", busy, m_cur > 0);
        check("tx_valid", tx_valid, m_txv_due);
        check("data_send", data_send, m_data);
        check("grant_id", grant_id, m_owner);
        check("stall", stall, m_stall_due && m_cur == 0);
        if (tx_valid) t_issue = cyc;
        if (stall) stall_dist = cyc - t_issue;
        m_txv_due = 1'b0;
        if (m_cur == 0 && m_stall_due) begin
            m_stall_due = 1'b0;
            m_lock      = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            r_valid[i] = (rq[i].size() > 0) && (!rand_en || $urandom_range(0, 9) != 0);
            r_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            r_lock[i] = (rq[i].size() > 0) && rq[i][0][8];
        end
        #1;
        exp_rdy = '0;
        w = -1;
        if (m_cur == 0) begin
            if (m_lock && !r_valid[m_owner]) m_lock = 1'b0;
            if (ready_tx && r_valid != '0) begin
                if (m_lock) begin
                    w = m_owner;
                end else begin
                    for (int k = 0; k < N; k++)
                        if (w < 0 && r_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                m_burst = (m_lock && w == m_owner) ? m_burst + 1 : 1;
                m_lock = r_lock[w] && (m_burst < MAXB);
                m_owner = w;
                m_ptr = (w + 1) % N;
                m_data = r_data[8*w +: 8];
                m_cur = stall_mode ? STALL + 1 : FRAME + 2;
                m_txv_due = 1'b1;
                m_stall_due = stall_mode;
                exp_log.push_back(m_data);
                exp_rdy[w] = 1'b1;
            end
        end else begin
            m_cur--;
        end
        check("req_ready", req_ready, exp_rdy);
        for (int i = 0; i < N; i++)
            if (req_ready[i] && r_valid[i]) void'(rq[i].pop_front());
        if (rand_en) begin
            for (int i = 0; i < N; i++)
                if (rq[i].size() == 0 && $urandom_range(0, 3) == 0)
                    rq[i].push_back({($urandom_range(0, 3) != 0), 8'($urandom)});
        end
    endtask

    task automatic run_idle(int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((pending() || m_cur != 0 || m_stall_due) && n < bound);
        check("timeout", pending() || m_cur != 0 || m_stall_due, 0);
    endtask

    task automatic check_tail(string tag, int base, logic [39:0] bytes, int n);
        check({tag, "_count"}, tx_log.size() - base, n);
        for (int k = 0; k < n; k++)
            if (base + k < tx_log.size())
                check(tag, tx_log[base + k], bytes[8*(n-1-k) +: 8]);
    endtask

    initial begin
        int base;
        model_reset();

        // Reset state, with requests present to show ready stays low.
        r_valid = '1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_data", data_send, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_gid", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        r_valid = '0;
        rst_n = 1'b1;

        // Fairness from reset.
        base = tx_log.size();
        rq[0].push_back({1'b0, 8'h10});
        rq[0].push_back({1'b0, 8'h14});
        rq[1].push_back({1'b0, 8'h11});
        rq[2].push_back({1'b0, 8'h12});
        rq[3].push_back({1'b0, 8'h13});
        run_idle(300);
        check_tail("fair", base, {8'h10, 8'h11, 8'h12, 8'h13, 8'h14}, 5);

        // Single requester.
        base = tx_log.size();
        rq[2].push_back({1'b0, 8'hA5});
        run_idle(100);
        check_tail("single", base, 40'hA5, 1);
        check("single_gid", grant_id, 2);
        check("single_data", data_send, 8'hA5);

        // Burst lock: req 1 keeps the transmitter for its message.
        base = tx_log.size();
        rq[1].push_back({1'b1, 8'h3C});
        rq[1].push_back({1'b1, 8'hC3});
        rq[1].push_back({1'b0, 8'h5A});
        tick();
        rq[0].push_back({1'b0, 8'h77});
        run_idle(300);
        check_tail("burst", base, {8'h3C, 8'hC3, 8'h5A, 8'h77}, 4);

        // Burst cap: rotation forced after MAXB bytes.
        base = tx_log.size();
        for (int k = 1; k <= 4; k++) rq[1].push_back({1'b1, 8'(8'hA0 + k)});
        rq[0].push_back({1'b0, 8'hB0});
        run_idle(300);
        check_tail("cap", base, {8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hA4}, 5);

        // Randomized traffic.
        rand_en = 1'b1;
        for (int c = 0; c < 1200; c++) tick();
        rand_en = 1'b0;
        run_idle(1000);

        // Stall: transmitter never reports busy.
        stall_mode = 1'b1;
        base = tx_log.size();
        stall_dist = -1;
        rq[0].push_back({1'b1, 8'h55});
        run_idle(100);
        check("stall_dist", stall_dist, STALL + 1);
        check_tail("stall", base, 40'h55, 1);
        stall_mode = 1'b0;
        tick();

        // Reset while waiting for the frame to finish.
        rq[2].push_back({1'b0, 8'hE7});
        begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (m_cur != 3 && n < 50);
        end
        @(negedge clk);
        check("wd_busy", busy, 1);
        check("wd_ready_tx", ready_tx, 0);
        rst_n = 1'b0;
        r_valid = 4'b1010;
        #1;
        check("mid_ready", req_ready, 0);
        check("mid_data", data_send, 0);
        check("mid_txv", tx_valid, 0);
        check("mid_gid", grant_id, 0);
        check("mid_busy", busy, 0);
        check("mid_stall", stall, 0);
        @(negedge clk);
        r_valid = '0;
        rst_n = 1'b1;
        model_reset();
        base = tx_log.size();
        rq[1].push_back({1'b0, 8'h61});
        rq[3].push_back({1'b0, 8'h63});
        run_idle(100);
        check_tail("post_rst", base, {8'h61, 8'h63}, 2);
        check("post_rst_gid", grant_id, 3);

        // Everything transmitted matches the reference order.
        check("log_len", tx_log.size(), exp_log.size());
        for (int k = 0; k < exp_log.size(); k++)
            if (k < tx_log.size()) check("log", tx_log[k], exp_log[k]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` instance among `NUM_REQ` byte producers. It sits directly in front of `uart_tx`. It accepts one byte at a time from requesters over valid/ready handshakes and drives `data_send`/`tx_valid`. It tracks `ready_tx` to sequence frames. Optional per-requester burst lock lets a producer send multi-byte messages without interleaving, capped at `MAX_BURST` bytes.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum consecutive bytes granted to one locked requester.
- `STALL_CYCLES`, 8: cycles to wait for `ready_tx` to fall after a push before declaring a stall.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous reset, active-low.
- `i_req_valid`  in  NUM_REQ  requester i has a byte.
- `i_req_data`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- `i_req_lock`  in  NUM_REQ  requester i asks to keep the grant after this byte.
- `o_req_ready`  out  NUM_REQ  one-hot accept; a transfer happens when valid&ready at a clock edge.
- `o_data_send`  out  8  to `uart_tx.data_send`.
- `o_tx_valid`  out  1  to `uart_tx.tx_valid`; one-cycle pulse.
- `i_ready_tx`  in  1  from `uart_tx.ready_tx`.
- `o_grant_id`  out  3  index of the requester currently owning the transmitter.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_stall`  out  1  one-cycle pulse on stall timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If `i_ready_tx`=1 and any `i_req_valid`, a winner w is chosen and `o_req_ready[w]`=1 combinationally.
  - At the edge: `o_data_send`<=data[w], `o_grant_id`<=w, state goes to ISSUE.
  - No grant is issued while `i_ready_tx`=0.
- **Winner selection**
  - If `lock_held` is set and the owner's valid is high, the owner wins.
  - Otherwise, first valid requester searching from `rr_ptr` upward with wrap-around.
  - If `lock_held` is set but the owner's valid is low, the lock is dropped and normal round-robin applies.
- **Pointer and burst count on grant**
  - `rr_ptr` <= (w+1) mod NUM_REQ.
  - `burst_cnt` is incremented if w equals the previous owner and the lock was held; otherwise it is set to 1.
  - `lock_held` <= `i_req_lock[w]` && `burst_cnt_next` < MAX_BURST.
  - At MAX_BURST, rotation is forced even if lock stays asserted.
- **ISSUE**: `o_tx_valid`=1 for exactly this cycle; go to WAIT_BUSY.
- **WAIT_BUSY**
  - Waits for `i_ready_tx`=0, then goes to WAIT_DONE.
  - The stall counter runs from 0. If it reaches STALL_CYCLES with `i_ready_tx` still 1: pulse `o_stall`, clear `lock_held`, go to IDLE. The byte is lost and the requester is not notified.
- **WAIT_DONE**: waits for `i_ready_tx`=1, then goes to IDLE.
- `o_req_ready` is zero in every state except IDLE.

## Timing
- Reset values: state IDLE; `rr_ptr`=0; `burst_cnt`=0; `lock_held`=0. All outputs are 0: `o_req_ready`, `o_data_send`, `o_tx_valid`, `o_grant_id`, `o_busy`, `o_stall`.
- Latency: accept edge to `o_tx_valid` high is 1 cycle.
- `o_data_send` is stable from ISSUE until the next grant.
- Minimum spacing between accepts is one UART frame plus 3 cycles (ISSUE, the WAIT_BUSY exit cycle, the WAIT_DONE exit cycle).
- Requester valid may drop at any time before acceptance. No byte is taken without valid&ready at the same edge.
- Simultaneous requests go to the round-robin order. With all valid from reset, the grant order is 0,1,2,3,0…
- Reset mid-frame returns to reset values immediately. `o_tx_valid` is never re-pulsed for an interrupted byte.

## Structure
- Shared package `uart_pkg`: FSM state encodings and the default `STALL_CYCLES`.
- Sub-module `rr_select`: purely combinational one-hot round-robin picker with a pointer input and a valid vector. Reused for future RX-side sharing.
- The top contains the FSM, counters, and output registers.

## Test plan
- **Single requester**: req 2 sends 0xA5 -> one `o_tx_valid` pulse, `o_data_send`=0xA5, `o_grant_id`=2, and the loopback `uart_rx` returns 0xA5 with no parity or framing error.
- **Fairness**: all four valid with 0x10..0x13, no lock -> bytes transmitted in order 0x10, 0x11, 0x12, 0x13, then req 0 again.
- **Burst lock**: req 1 holds lock for 3 bytes 0x3C, 0xC3, 0x5A while req 0 is valid -> req 1's three bytes go out before req 0's byte. With MAX_BURST=2, req 0 is served after two bytes.
- **Stall**: tie `i_ready_tx` high and request 0x55 -> `o_stall` pulses exactly STALL_CYCLES+1 cycles after ISSUE, then state is IDLE.
- **Reset mid-operation**: assert `i_rst_n`=0 in WAIT_DONE -> all outputs 0 immediately. After release, req 3 is granted with `rr_ptr` back at 0 priority.
